// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Sequencing controller for the IF/ID and ID/EX pipeline registers of the
// 5-stage core. It compares the ID-stage source registers against the EXE and
// MEM destinations to find RAW hazards. It also turns taken branches into
// IF/ID flushes and freezes the whole pipe while data memory is busy.
// Saturating stall/flush counters are kept for performance debug.
//
// Build option:
//   FORWARDING_EN  defined   -> EXE/MEM forwarding exists; only load-use
//                               (EXE load feeding an ID source) stalls.
//                  undefined -> any EXE or MEM writeback match stalls.
//
// Parameters:
//   CNT_W        width of stall_cnt / flush_cnt
//   MEM_TIMEOUT  MEM_WAIT cycles before the access is abandoned (1..4095)
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   id_src1/_vld, id_src2/_vld    ID-stage source registers and read enables
//   exe_dest, exe_wb_en           EXE destination and writeback enable
//   exe_mem_r_en                  EXE instruction is a load
//   mem_dest, mem_wb_en           MEM destination and writeback enable
//   branch_taken                  taken branch resolved in EXE
//   mem_req, mem_ready            data-memory request / completion
//   hold_if_id                    PC and IF/ID keep their value
//   bubble_id_ex                  ID/EX loads a NOP
//   flush_if_id                   IF/ID loads a NOP
//   freeze_all                    every pipeline register holds
//   mem_timeout                   sticky flag: a memory wait was abandoned
//   stall_cnt, flush_cnt          saturating hazard-stall / flush counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; a pending memory access enters MEM_WAIT
// MEM_WAIT | memory busy; pipe frozen until ready or timeout
//------------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_vld,
  input  logic [3:0]       id_src2,
  input  logic             id_src2_vld,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hold_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int               WAIT_W   = 12;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]       PC_REG   = 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze;
  logic              timeout_set;
  logic              hazard;

  // The PC reads as a live value in every stage, so it never creates a hazard.
  logic src1_rd, src2_rd;
  logic exe_hit1, exe_hit2;

  assign src1_rd  = id_src1_vld & (id_src1 != PC_REG);
  assign src2_rd  = id_src2_vld & (id_src2 != PC_REG);
  assign exe_hit1 = src1_rd & exe_wb_en & (exe_dest == id_src1);
  assign exe_hit2 = src2_rd & exe_wb_en & (exe_dest == id_src2);

`ifdef FORWARDING_EN
  // ALU results are forwarded from EXE and MEM; only a load in EXE cannot be
  // forwarded in time, so that costs one stall cycle.
  logic unused_mem_fwd;
  assign unused_mem_fwd = ^{mem_dest, mem_wb_en};
  assign hazard = exe_mem_r_en & (exe_hit1 | exe_hit2);
`else
  logic mem_hit1, mem_hit2;
  logic unused_load_flag;
  assign unused_load_flag = exe_mem_r_en;
  assign mem_hit1 = src1_rd & mem_wb_en & (mem_dest == id_src1);
  assign mem_hit2 = src2_rd & mem_wb_en & (mem_dest == id_src2);
  assign hazard   = exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2;
`endif

  // Next-state and freeze decode.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    freeze      = 1'b0;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          // The request cycle itself is the first frozen cycle.
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          // Give up on the access and let the pipe move again.
          timeout_set = 1'b1;
          state_nxt   = RUN;
          wait_nxt    = '0;
        end else begin
          freeze   = 1'b1;
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Pipeline controls. Freeze masks branch and hazard handling entirely; they
  // are re-evaluated on the first cycle the pipe is allowed to move.
  always_comb begin
    hold_if_id   = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    freeze_all   = 1'b0;
    if (!rst) begin
      freeze_all = freeze;
      if (!freeze) begin
        if (branch_taken) begin
          flush_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end else if (hazard) begin
          hold_if_id   = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      if (hold_if_id && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_if_id && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Expected values are hand-derived for
// both builds (FORWARDING_EN defined or not). The DUT runs with a small
// counter width and a short memory timeout so saturation and timeout are
// reached quickly.
//------------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [3:0]       id_src1;
  logic             id_src1_vld;
  logic [3:0]       id_src2;
  logic             id_src2_vld;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             hold_if_id;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             freeze_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  pipe_hazard_ctrl #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .id_src1     (id_src1),
    .id_src1_vld (id_src1_vld),
    .id_src2     (id_src2),
    .id_src2_vld (id_src2_vld),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .hold_if_id  (hold_if_id),
    .bubble_id_ex(bubble_id_ex),
    .flush_if_id (flush_if_id),
    .freeze_all  (freeze_all),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input bit hold, input bit bub,
                         input bit flush, input bit frz);
    chk({tag, ".hold"},   32'(hold_if_id),   32'(hold));
    chk({tag, ".bubble"}, 32'(bubble_id_ex), 32'(bub));
    chk({tag, ".flush"},  32'(flush_if_id),  32'(flush));
    chk({tag, ".freeze"}, 32'(freeze_all),   32'(frz));
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src1_vld = 1'b0;
    id_src2 = 4'd0; id_src2_vld = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with every request active: outputs must stay low.
    rst = 1'b1;
    idle();
    branch_taken = 1'b1; mem_req = 1'b1;
    id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #3;
    chk_ctl("rst", 0, 0, 0, 0);
    tick();
    chk("rst.stall", 32'(stall_cnt), 0);
    chk("rst.flush", 32'(flush_cnt), 0);
    chk("rst.tmo",   32'(mem_timeout), 0);
    idle();
    rst = 1'b0;

    // ALU result in EXE feeding src1.
    id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 chk_ctl("alu_exe", !FWD, !FWD, 0, 0);
    tick();
    chk("alu_exe.stall", 32'(stall_cnt), FWD ? 0 : 1);

    // Same register now only in MEM.
    exe_wb_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1 chk_ctl("alu_mem", !FWD, !FWD, 0, 0);
    tick();
    chk("alu_mem.stall", 32'(stall_cnt), FWD ? 0 : 2);

    // Load in EXE feeding src1: stalls in both builds.
    mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk_ctl("load_use", 1, 1, 0, 0);
    tick();
    chk("load_use.stall", 32'(stall_cnt), FWD ? 1 : 3);

    // The load moved to MEM: forwarding build needs no second stall.
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1 chk_ctl("load_mem", !FWD, !FWD, 0, 0);
    tick();
    chk("load_mem.stall", 32'(stall_cnt), FWD ? 1 : 4);

    // PC as source never hazards.
    idle();
    id_src1 = 4'd15; id_src1_vld = 1'b1;
    exe_dest = 4'd15; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    mem_dest = 4'd15; mem_wb_en = 1'b1;
    #1 chk_ctl("pc_src", 0, 0, 0, 0);
    tick();

    // Source not read: no hazard.
    idle();
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk_ctl("src_invalid", 0, 0, 0, 0);
    tick();
    chk("src_invalid.stall", 32'(stall_cnt), FWD ? 1 : 4);

    // Load-use on src2.
    idle();
    id_src2 = 4'd5; id_src2_vld = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk_ctl("src2_load", 1, 1, 0, 0);
    tick();
    chk("src2_load.stall", 32'(stall_cnt), FWD ? 2 : 5);

    // Branch beats hazard in the same cycle.
    branch_taken = 1'b1;
    #1 chk_ctl("br_haz", 0, 1, 1, 0);
    tick();
    chk("br_haz.flush", 32'(flush_cnt), 1);
    chk("br_haz.stall", 32'(stall_cnt), FWD ? 2 : 5);

    // Memory busy 4 cycles with a branch held across the freeze.
    idle();
    branch_taken = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl("frz_br", 0, 0, 0, 1);
      tick();
      chk("frz_br.flush_cnt", 32'(flush_cnt), 1);
    end
    mem_ready = 1'b1;
    #1 chk_ctl("frz_ready", 0, 1, 1, 0);
    tick();
    chk("frz_ready.flush_cnt", 32'(flush_cnt), 2);

    // Request completing immediately: no freeze.
    branch_taken = 1'b0;
    #1 chk_ctl("mem_fast", 0, 0, 0, 0);
    tick();

    // Memory never ready: timeout after 8 frozen cycles.
    idle();
    mem_req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1 chk("tmo.freeze", 32'(freeze_all), 1);
      tick();
      chk("tmo.flag_low", 32'(mem_timeout), 0);
    end
    #1 chk("tmo.release", 32'(freeze_all), 0);
    tick();
    chk("tmo.flag", 32'(mem_timeout), 1);
    idle();
    #1 chk("tmo.state_run", 32'(freeze_all), 0);
    tick();
    chk("tmo.sticky", 32'(mem_timeout), 1);

    // Stall counter saturates at 15.
    id_src1 = 4'd7; id_src1_vld = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #1 chk_ctl("sat_stall", 1, 1, 0, 0);
    chk("sat_stall.cnt", 32'(stall_cnt), 15);

    // Flush counter saturates at 15.
    idle();
    branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_flush.cnt", 32'(flush_cnt), 15);

    // Asynchronous reset in the middle of a memory wait.
    idle();
    mem_req = 1'b1; branch_taken = 1'b1;
    tick();
    #1 chk("arst.pre_freeze", 32'(freeze_all), 1);
    #2 rst = 1'b1;
    #1 chk_ctl("arst", 0, 0, 0, 0);
    chk("arst.stall", 32'(stall_cnt), 0);
    chk("arst.flush", 32'(flush_cnt), 0);
    chk("arst.tmo",   32'(mem_timeout), 0);
    tick();
    rst = 1'b0;
    idle();
    #1 chk("arst.state_run", 32'(freeze_all), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
